// File: rtl/tdm_demux2.sv
// Receive end of the 2:1 tagged serial link: splits the shared bit line into
// two independent W-bit words, each presented with a one-cycle valid strobe.

module tdm_demux2_lane #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         acc_i,
   input  logic         y_i,
   output logic [W-1:0] data_o,
   output logic         valid_o
);
   localparam int CW = $clog2(W);

   logic [W-2:0]  sh_q, sh_d, sh_base;
   logic [CW-1:0] cnt_q, cnt_d, cnt_base;
   logic [W-1:0]  data_q, data_d, word;
   logic          valid_q, valid_d;

   // A frame clear takes effect before the bit of the same cycle lands.
   always_comb begin
      sh_base  = clr_i ? '0 : sh_q;
      cnt_base = clr_i ? '0 : cnt_q;
      word     = {sh_base, y_i};
      sh_d     = sh_base;
      cnt_d    = cnt_base;
      data_d   = data_q;
      valid_d  = 1'b0;
      if (acc_i) begin
         if (cnt_base == CW'(W - 1)) begin
            data_d  = word;
            valid_d = 1'b1;
            cnt_d   = '0;
         end else begin
            sh_d  = word[W-2:0];
            cnt_d = cnt_base + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q    <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
endmodule

module tdm_demux2 #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         sync_i,
   input  logic         en_i,
   input  logic         s_i,
   input  logic         y_i,
   output logic [W-1:0] a_data_o,
   output logic         a_valid_o,
   output logic [W-1:0] b_data_o,
   output logic         b_valid_o,
   output logic         err_o
);
   localparam int NUM_LANES = 2;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                          state_q;
   logic                            err_q;
   logic                            accept;
   logic [NUM_LANES-1:0]            acc;
   logic [NUM_LANES-1:0][W-1:0]     data;
   logic [NUM_LANES-1:0]            valid;

   // sync in IDLE opens the frame and admits the bit of that same cycle
   assign accept = en_i & ((state_q == RUN) | sync_i);
   assign acc    = {accept & s_i, accept & ~s_i};

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      tdm_demux2_lane #(.W(W)) u_lane (
         .clk    (clk),
         .rst_n  (rst_n),
         .clr_i  (sync_i),
         .acc_i  (acc[g]),
         .y_i    (y_i),
         .data_o (data[g]),
         .valid_o(valid[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         err_q   <= 1'b0;
      end else begin
         if (sync_i)
            err_q <= 1'b0;
         else if (state_q == IDLE && en_i)
            err_q <= 1'b1;
         if (sync_i)
            state_q <= RUN;
      end
   end

   assign a_data_o  = data[0];
   assign a_valid_o = valid[0];
   assign b_data_o  = data[1];
   assign b_valid_o = valid[1];
   assign err_o     = err_q;
endmodule

// File: tb/tb_tdm_demux2.sv
// Randomized and directed bench for tdm_demux2 against a queue-based frame model.

module tb_tdm_demux2;
   localparam int W = 4;

   logic         clk, rst_n;
   logic         sync_i, en_i, s_i, y_i;
   logic [W-1:0] a_data_o, b_data_o;
   logic         a_valid_o, b_valid_o, err_o;

   int n_chk = 0;
   int n_fail = 0;

   tdm_demux2 #(.W(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sync_i   (sync_i),
      .en_i     (en_i),
      .s_i      (s_i),
      .y_i      (y_i),
      .a_data_o (a_data_o),
      .a_valid_o(a_valid_o),
      .b_data_o (b_data_o),
      .b_valid_o(b_valid_o),
      .err_o    (err_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   // reference model: bits of each channel's open word, kept in arrival order
   bit           m_run, m_err;
   bit           qa[$], qb[$];
   logic [W-1:0] m_ad, m_bd;
   bit           m_av, m_bv;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] pack(input bit q[$]);
      logic [W-1:0] v = '0;
      foreach (q[i]) v = (v << 1) | W'(q[i]);
      return v;
   endfunction

   task automatic m_reset();
      m_run = 0; m_err = 0; qa.delete(); qb.delete();
      m_ad = '0; m_bd = '0; m_av = 0; m_bv = 0;
   endtask

   task automatic m_step(input bit sy, input bit en, input bit s, input bit y);
      m_av = 0; m_bv = 0;
      if (sy) begin qa.delete(); qb.delete(); end
      if (en && (m_run || sy)) begin
         if (!s) begin
            qa.push_back(y);
            if (qa.size() == W) begin m_ad = pack(qa); m_av = 1; qa.delete(); end
         end else begin
            qb.push_back(y);
            if (qb.size() == W) begin m_bd = pack(qb); m_bv = 1; qb.delete(); end
         end
      end
      if (sy) m_err = 0;
      else if (!m_run && en) m_err = 1;
      if (sy) m_run = 1;
   endtask

   task automatic check_all();
      chk("a_data", 16'(a_data_o), 16'(m_ad));
      chk("a_valid", 16'(a_valid_o), 16'(m_av));
      chk("b_data", 16'(b_data_o), 16'(m_bd));
      chk("b_valid", 16'(b_valid_o), 16'(m_bv));
      chk("err", 16'(err_o), 16'(m_err));
   endtask

   task automatic cycle(input bit sy, input bit en, input bit s, input bit y);
      sync_i = sy; en_i = en; s_i = s; y_i = y;
      @(posedge clk);
      if (!rst_n) m_reset();
      else m_step(sy, en, s, y);
      #1 check_all();
   endtask

   task automatic async_rst();
      #2 rst_n = 1'b0;
      #1 m_reset();
      check_all();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      sync_i = 0; en_i = 0; s_i = 0; y_i = 0;
      m_reset();
      // reset held with random inputs
      for (int i = 0; i < 4; i++)
         cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      cycle(0, 1, 0, 1);
      chk("err_no_sync", 16'(err_o), 16'd1);
      chk("no_valid_idle", 16'({a_valid_o, b_valid_o}), 16'd0);
      cycle(0, 1, 1, 1);

      // single channel a: 1011
      cycle(1, 0, 0, 0);
      chk("err_cleared", 16'(err_o), 16'd0);
      cycle(0, 1, 0, 1); cycle(0, 1, 0, 0); cycle(0, 1, 0, 1); cycle(0, 1, 0, 1);
      chk("single_a_data", 16'(a_data_o), 16'hB);
      chk("single_a_valid", 16'(a_valid_o), 16'd1);
      cycle(0, 0, 0, 0);
      chk("single_a_strobe_1cyc", 16'(a_valid_o), 16'd0);

      // interleave a=1100, b=0101
      cycle(1, 0, 0, 0);
      cycle(0, 1, 0, 1); cycle(0, 1, 1, 0); cycle(0, 1, 0, 1); cycle(0, 1, 1, 1);
      cycle(0, 1, 0, 0); cycle(0, 1, 1, 0); cycle(0, 1, 0, 0);
      chk("ilv_a_data", 16'(a_data_o), 16'hC);
      cycle(0, 1, 1, 1);
      chk("ilv_b_data", 16'(b_data_o), 16'h5);
      chk("ilv_b_valid", 16'(b_valid_o), 16'd1);
      cycle(0, 0, 0, 0);
      chk("ilv_a_hold", 16'(a_data_o), 16'hC);

      // mid-word sync with a bit in the same cycle
      cycle(0, 1, 0, 1); cycle(0, 1, 0, 1);
      cycle(1, 1, 0, 1);
      cycle(0, 1, 0, 0); cycle(0, 1, 0, 0); cycle(0, 1, 0, 1);
      chk("midsync_a_data", 16'(a_data_o), 16'h9);
      chk("midsync_err", 16'(err_o), 16'd0);

      // en gaps, mixed channels
      cycle(0, 1, 0, 0); cycle(0, 0, 1, 1); cycle(0, 1, 1, 1); cycle(0, 0, 0, 1);
      cycle(0, 1, 0, 1); cycle(0, 0, 0, 0); cycle(0, 1, 0, 1); cycle(0, 0, 1, 0);
      cycle(0, 1, 0, 0);
      chk("gap_a_data", 16'(a_data_o), 16'h6);
      cycle(0, 0, 1, 1);
      chk("gap_a_strobe_1cyc", 16'(a_valid_o), 16'd0);

      // reset mid-word on channel b
      cycle(1, 0, 0, 0);
      cycle(0, 1, 1, 1); cycle(0, 1, 1, 1); cycle(0, 1, 1, 1);
      async_rst();
      cycle(0, 1, 1, 0);
      chk("rst_no_strobe", 16'(b_valid_o), 16'd0);
      cycle(1, 0, 0, 0);
      cycle(0, 1, 1, 1); cycle(0, 1, 1, 1); cycle(0, 1, 1, 1); cycle(0, 1, 1, 0);
      chk("rst_b_data", 16'(b_data_o), 16'hE);

      // random traffic with occasional frame syncs and resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) async_rst();
         cycle($urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7,
               1'($urandom), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
